// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: FSM state encoding and widths shared by the SDRAM read arbiter
`ifndef NUMCACHES
`define NUMCACHES 3
`endif
`ifndef maxTrans
`define maxTrans 16
`endif
package cache_mem_arbiter_pkg;
  localparam int NUM_CLIENTS = `NUMCACHES;
  localparam int MAX_TRANS = `maxTrans;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
  localparam int SIZE_W = $clog2(MAX_TRANS);
  localparam int IDX_W = $clog2(NUM_CLIENTS);
  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DONE} memarb_state_t;
endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter.sv
// cache_mem_arbiter_rr_arbiter: combinational pick of the first request at or after ptr, wrapping
module cache_mem_arbiter_rr_arbiter #(
  parameter int N = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W-1:0] c;
  assign any = |req;
  always_comb begin
    gnt = '0;
    idx = '0;
    c = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = IDX_W'((int'(ptr) + k) % N);
      if (req[c]) begin
        gnt = '0;
        gnt[c] = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: one-burst-at-a-time SDRAM read arbiter; MEMARB_FIXED_PRI_EN selects fixed lowest-index priority instead of round-robin
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] addr_cache_to_sdram,
  input  logic [NUM_CLIENTS-1:0][SIZE_W-1:0] transSize,
  input  logic [NUM_CLIENTS-1:0]             readReq,
  output logic [NUM_CLIENTS-1:0]             readValid_out,
  output logic [NUM_CLIENTS-1:0][DATA_W-1:0] readData,
  output logic [NUM_CLIENTS-1:0]             doneRead,
  output logic                               sdram_rd_req,
  output logic [ADDR_W-1:0]                  sdram_addr,
  output logic [SIZE_W-1:0]                  sdram_trans_size,
  input  logic                               sdram_rd_ack,
  input  logic                               sdram_rd_valid,
  input  logic [DATA_W-1:0]                  sdram_rd_data
);
  memarb_state_t state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] pick_idx;
  logic [NUM_CLIENTS-1:0] pick_gnt;
  logic [NUM_CLIENTS-1:0] grant_oh;
  logic pick_any;
  logic take;
  logic [SIZE_W-1:0] cnt;
  cache_mem_arbiter_rr_arbiter #(.N(NUM_CLIENTS), .IDX_W(IDX_W)) u_rr (
    .req(readReq),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign take = state == STREAM && sdram_rd_valid;
  assign readValid_out = take ? grant_oh : '0;
  assign readData = {NUM_CLIENTS{sdram_rd_data & {DATA_W{take}}}};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      grant_oh <= '0;
      cnt <= '0;
      doneRead <= '0;
      sdram_rd_req <= 1'b0;
      sdram_addr <= '0;
      sdram_trans_size <= '0;
    end else begin
      doneRead <= '0;
      case (state)
        IDLE: if (pick_any) begin
          state <= ISSUE;
          grant <= pick_idx;
          grant_oh <= pick_gnt;
          sdram_rd_req <= 1'b1;
          sdram_addr <= addr_cache_to_sdram[pick_idx];
          sdram_trans_size <= transSize[pick_idx];
        end
        ISSUE: if (sdram_rd_ack) begin
          state <= STREAM;
          sdram_rd_req <= 1'b0;
          cnt <= '0;
        end
        STREAM: if (sdram_rd_valid) begin
          cnt <= cnt + 1'b1;
          if (cnt == sdram_trans_size) begin
            state <= DONE;
            doneRead <= grant_oh;
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef MEMARB_FIXED_PRI_EN
          ptr <= '0;
`else
          ptr <= (grant == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench for the SDRAM read arbiter (expectations follow MEMARB_FIXED_PRI_EN)
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_CLIENTS-1:0][SIZE_W-1:0] tsz;
  logic [NUM_CLIENTS-1:0] req;
  logic [NUM_CLIENTS-1:0] rvalid;
  logic [NUM_CLIENTS-1:0] done;
  logic [NUM_CLIENTS-1:0][DATA_W-1:0] rdata;
  logic rd_req;
  logic ack;
  logic vld;
  logic [ADDR_W-1:0] saddr;
  logic [SIZE_W-1:0] ssize;
  logic [DATA_W-1:0] sdata;
  int passed = 0;
  int total = 0;
  typedef struct packed {
    logic [NUM_CLIENTS-1:0] lane;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t sb[$];

  cache_mem_arbiter dut (
    .clk(clk),
    .rst(rst),
    .addr_cache_to_sdram(addr),
    .transSize(tsz),
    .readReq(req),
    .readValid_out(rvalid),
    .readData(rdata),
    .doneRead(done),
    .sdram_rd_req(rd_req),
    .sdram_addr(saddr),
    .sdram_trans_size(ssize),
    .sdram_rd_ack(ack),
    .sdram_rd_valid(vld),
    .sdram_rd_data(sdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    vld = 1'b0;
    sdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // SDRAM controller model: waits for the request, delays ack, streams sz+1 words
  // (plus an optional surplus word), and scores lanes, data and the doneRead pulse.
  task automatic serve(input int c, input logic [SIZE_W-1:0] sz, input int ack_dly,
                       input logic [DATA_W-1:0] base, input bit extra);
    int n = 0;
    exp_t e;
    logic [NUM_CLIENTS-1:0] lane;
    lane = NUM_CLIENTS'(1) << c;
    while (rd_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      ack = 1'b0;
      vld = 1'b0;
      #1;
      n++;
    end
    total++;
    if (rd_req !== 1'b1) begin
      $display("FAIL serve_req_timeout client %0d: sdram_rd_req=%b, required 1", c, rd_req);
      return;
    end
    passed++;
    total++;
    if (saddr !== addr[c] || ssize !== sz)
      $display("FAIL serve_addr client %0d: addr=%h size=%0d, required addr=%h size=%0d", c, saddr, ssize, addr[c], sz);
    else passed++;
    for (int k = 0; k < ack_dly; k++) begin
      @(negedge clk);
      ack = 1'b0;
      vld = 1'b1;
      sdata = 32'hDEAD0000 + DATA_W'(k);
      #1 total++;
      if (rd_req !== 1'b1 || saddr !== addr[c] || ssize !== sz || rvalid !== '0)
        $display("FAIL ack_wait cycle %0d: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0", k, rd_req, saddr, rvalid, addr[c]);
      else passed++;
    end
    @(negedge clk);
    ack = 1'b1;
    vld = 1'b1;
    sdata = 32'hBAD0BAD0;
    #1 total++;
    if (rvalid !== '0 || rd_req !== 1'b1)
      $display("FAIL ack_cycle_word: valid=%b req=%b, required valid=0 req=1", rvalid, rd_req);
    else passed++;
    for (int i = 0; i <= int'(sz) + 1; i++) begin
      @(negedge clk);
      ack = 1'b0;
      vld = (i <= int'(sz)) || extra;
      sdata = base + DATA_W'(i);
      if (i <= int'(sz)) begin
        e.lane = lane;
        e.data = base + DATA_W'(i);
        sb.push_back(e);
      end
      #1;
      if (i == 0) begin
        total++;
        if (rd_req !== 1'b0) $display("FAIL req_drop: sdram_rd_req=%b, required 0", rd_req);
        else passed++;
      end
      if (rvalid !== '0) begin
        total++;
        if (sb.size() == 0) $display("FAIL stray_word: valid=%b data=%h, required valid=0", rvalid, rdata[0]);
        else begin
          e = sb.pop_front();
          if (rvalid !== e.lane || rdata !== {NUM_CLIENTS{e.data}})
            $display("FAIL word: valid=%b data=%h, required valid=%b data=%h", rvalid, rdata, e.lane, {NUM_CLIENTS{e.data}});
          else passed++;
        end
      end
      total++;
      if (i == int'(sz) + 1) begin
        if (done !== lane) $display("FAIL done_pulse client %0d: doneRead=%b, required %b", c, done, lane);
        else passed++;
      end else begin
        if (done !== '0) $display("FAIL done_early word %0d: doneRead=%b, required 0", i, done);
        else passed++;
      end
    end
    total++;
    if (sb.size() != 0) begin
      $display("FAIL words_missing client %0d: %0d undelivered, required 0", c, sb.size());
      sb.delete();
    end else passed++;
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if (rd_req !== 1'b0 || saddr !== '0 || ssize !== '0 || rvalid !== '0 || done !== '0 || rdata !== '0)
      $display("FAIL reset_outputs: req=%b addr=%h size=%0d valid=%b done=%b, required all 0", rd_req, saddr, ssize, rvalid, done);
    else passed++;
    total++;
    if (dut.state !== IDLE || dut.ptr !== '0 || dut.cnt !== '0)
      $display("FAIL reset_state: state=%0d ptr=%0d cnt=%0d, required 0 0 0", dut.state, dut.ptr, dut.cnt);
    else passed++;
  endtask

  task automatic test_single;
    addr[1] = 25'h00100;
    tsz[1] = 4'd3;
    @(negedge clk);
    req = 3'b010;
    #1 total++;
    if (rd_req !== 1'b0) $display("FAIL latency_early: sdram_rd_req=%b, required 0", rd_req);
    else passed++;
    @(negedge clk);
    #1 total++;
    if (rd_req !== 1'b1 || saddr !== 25'h00100 || ssize !== 4'd3)
      $display("FAIL latency_issue: req=%b addr=%h size=%0d, required 1 00100 3", rd_req, saddr, ssize);
    else passed++;
    serve(1, 4'd3, 0, 32'hA0, 1'b0);
    @(negedge clk);
    req = '0;
    vld = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 total++;
      if (rd_req !== 1'b0 || done !== '0 || dut.state !== IDLE)
        $display("FAIL no_regrant: req=%b done=%b state=%0d, required 0 0 IDLE", rd_req, done, dut.state);
      else passed++;
    end
  endtask

  task automatic test_stray;
    req = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vld = 1'b1;
      sdata = 32'h5A5A0000 + DATA_W'(k);
      #1 total++;
      if (rvalid !== '0 || rdata !== '0 || rd_req !== 1'b0 || dut.state !== IDLE)
        $display("FAIL idle_valid %0d: valid=%b req=%b state=%0d, required 0 0 IDLE", k, rvalid, rd_req, dut.state);
      else passed++;
    end
    addr[2] = 25'h1ABCD;
    tsz[2] = 4'd3;
    @(negedge clk);
    vld = 1'b0;
    req = 3'b100;
    serve(2, 4'd3, 0, 32'hB0, 1'b1);
    @(negedge clk);
    req = '0;
    vld = 1'b0;
    #1 total++;
    if (dut.state !== IDLE || rvalid !== '0)
      $display("FAIL surplus_word: state=%0d valid=%b, required IDLE 0", dut.state, rvalid);
    else passed++;
  endtask

  task automatic test_ack_delay;
    addr[0] = 25'h02040;
    tsz[0] = 4'd2;
    @(negedge clk);
    vld = 1'b0;
    req = 3'b001;
    serve(0, 4'd2, 5, 32'hC0, 1'b0);
    @(negedge clk);
    req = '0;
    vld = 1'b0;
  endtask

  task automatic test_rst_mid;
    addr[2] = 25'h1F000;
    tsz[2] = 4'd7;
    @(negedge clk);
    req = 3'b100;
    @(negedge clk);
    #1 total++;
    if (rd_req !== 1'b1 || saddr !== 25'h1F000)
      $display("FAIL rst_mid_issue: req=%b addr=%h, required 1 1f000", rd_req, saddr);
    else passed++;
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    vld = 1'b1;
    sdata = 32'hE0;
    #1 total++;
    if (rvalid !== 3'b100 || rdata[2] !== 32'hE0)
      $display("FAIL rst_mid_word0: valid=%b data=%h, required 100 e0", rvalid, rdata[2]);
    else passed++;
    @(negedge clk);
    sdata = 32'hE1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vld = 1'b0;
    req = '0;
    #1 total++;
    if (rd_req !== 1'b0 || saddr !== '0 || ssize !== '0 || rvalid !== '0 || done !== '0 || rdata !== '0 || dut.state !== IDLE)
      $display("FAIL rst_mid_clear: req=%b addr=%h valid=%b done=%b state=%0d, required all 0 IDLE", rd_req, saddr, rvalid, done, dut.state);
    else passed++;
    addr[0] = 25'h00777;
    tsz[0] = 4'd1;
    @(negedge clk);
    req = 3'b101;
    serve(0, 4'd1, 0, 32'hF0, 1'b0);
    @(negedge clk);
    req = '0;
    vld = 1'b0;
  endtask

  task automatic test_rotation;
    int c;
    do_reset();
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      addr[k] = ADDR_W'(32'h0100000 * (k + 1));
      tsz[k] = '0;
    end
    @(negedge clk);
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
`ifdef MEMARB_FIXED_PRI_EN
      c = 0;
`else
      c = k % NUM_CLIENTS;
`endif
      serve(c, '0, 0, 32'h100 + DATA_W'(k), 1'b0);
    end
    @(negedge clk);
    req = '0;
    vld = 1'b0;
  endtask

  task automatic test_priority;
    int c;
    do_reset();
    addr[0] = 25'h0AAAA;
    addr[2] = 25'h15555;
    tsz[0] = 4'd1;
    tsz[2] = 4'd0;
    @(negedge clk);
    req = 3'b101;
    for (int k = 0; k < 4; k++) begin
`ifdef MEMARB_FIXED_PRI_EN
      c = 0;
`else
      c = (k % 2 == 1) ? 2 : 0;
`endif
      serve(c, tsz[c], 0, 32'h200 + DATA_W'(k * 16), 1'b0);
    end
    @(negedge clk);
    req = '0;
    vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    vld = 1'b0;
    sdata = '0;
    addr = '0;
    tsz = '0;
    test_reset();
    test_single();
    test_stray();
    test_ack_delay();
    test_rst_mid();
    test_rotation();
    test_priority();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
